// File: rtl/cnn_bn_relu_stream.sv
// Folded batch-norm (y = x*scale + bias) plus ReLU on a channel-major pixel stream, 3-cycle latency.
// Define BN_RELU6_EN to additionally clamp the rectified output to 6.0 (ReLU6).
module cnn_bn_relu_stream #(
  parameter int DATA_WIDTH      = 16,
  parameter int FRAC_BITS       = 8,
  parameter int IMAGE_WIDTH     = 153,
  parameter int IMAGE_HEIGHT    = 153,
  parameter int IMAGE_SIZE      = IMAGE_WIDTH * IMAGE_HEIGHT,
  parameter int CHANNEL_NUM_OUT = 2048,
  parameter int CH_CNT_WIDTH    = 11,
  parameter int PXL_CNT_WIDTH   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_coef_in,
  input  logic [DATA_WIDTH-1:0] coef_in,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  coef_loaded,
  output logic                  frame_done,
  output logic                  err_early_pxl
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = PW + 2;
  localparam logic [CH_CNT_WIDTH-1:0]  CH_LAST  = CH_CNT_WIDTH'(CHANNEL_NUM_OUT - 1);
  localparam logic [PXL_CNT_WIDTH-1:0] PXL_LAST = PXL_CNT_WIDTH'(IMAGE_SIZE - 1);
  localparam logic signed [SW-1:0] RND_HALF = SW'(1) << (FRAC_BITS - 1);
  localparam logic signed [SW-1:0] SAT_MAX  = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
`ifdef BN_RELU6_EN
  localparam logic signed [SW-1:0] SIX_MAX  = SW'(6) << FRAC_BITS;
`endif

  typedef enum logic {LOAD, RUN} state_t;
  state_t state_reg, state_next;

  logic                           coef_sel_reg;
  logic [CH_CNT_WIDTH-1:0]        ch_cnt_reg;
  logic [PXL_CNT_WIDTH-1:0]       pxl_cnt_reg;
  logic                           v1_reg, v2_reg, last1_reg, last2_reg;
  logic signed [DATA_WIDTH-1:0]   x1_reg, scale_rd_reg, bias_rd_reg, bias2_reg;
  logic signed [PW-1:0]           prod2_reg;
  logic signed [SW-1:0]           p_ext, r_val, s_val;
  logic [DATA_WIDTH-1:0]          bn_out;
  logic [DATA_WIDTH-1:0]          scale_mem [CHANNEL_NUM_OUT];
  logic [DATA_WIDTH-1:0]          bias_mem  [CHANNEL_NUM_OUT];

  logic load_wr, accept, last_pxl;
  assign load_wr     = valid_coef_in && (state_reg == LOAD);
  assign accept      = valid_in && (state_reg == RUN);
  assign last_pxl    = (ch_cnt_reg == CH_LAST) && (pxl_cnt_reg == PXL_LAST);
  assign coef_loaded = (state_reg == RUN);

  always_comb begin
    state_next = state_reg;
    if (load_wr && coef_sel_reg && (ch_cnt_reg == CH_LAST))
      state_next = RUN;
  end

  // ch_cnt_reg is the write address while loading and the read address while running
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= LOAD;
      coef_sel_reg  <= 1'b0;
      ch_cnt_reg    <= '0;
      pxl_cnt_reg   <= '0;
      err_early_pxl <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (valid_in && (state_reg == LOAD))
        err_early_pxl <= 1'b1;
      if (load_wr) begin
        coef_sel_reg <= ~coef_sel_reg;
        if (coef_sel_reg)
          ch_cnt_reg <= (ch_cnt_reg == CH_LAST) ? '0 : ch_cnt_reg + CH_CNT_WIDTH'(1);
      end
      if (accept) begin
        if (pxl_cnt_reg == PXL_LAST) begin
          pxl_cnt_reg <= '0;
          ch_cnt_reg  <= (ch_cnt_reg == CH_LAST) ? '0 : ch_cnt_reg + CH_CNT_WIDTH'(1);
        end else begin
          pxl_cnt_reg <= pxl_cnt_reg + PXL_CNT_WIDTH'(1);
        end
      end
    end
  end

  // Read uses the pre-increment channel, so each pixel sees its own channel's coefficients
  always_ff @(posedge clk) begin
    if (load_wr && !coef_sel_reg)
      scale_mem[ch_cnt_reg] <= coef_in;
    if (load_wr && coef_sel_reg)
      bias_mem[ch_cnt_reg] <= coef_in;
    if (accept) begin
      scale_rd_reg <= scale_mem[ch_cnt_reg];
      bias_rd_reg  <= bias_mem[ch_cnt_reg];
    end
  end

  always_comb begin
    p_ext  = SW'(prod2_reg);
    r_val  = (p_ext + RND_HALF) >>> FRAC_BITS;
    s_val  = r_val + SW'(bias2_reg);
    bn_out = s_val[DATA_WIDTH-1:0];
    if (s_val[SW-1])
      bn_out = '0;
    else if (s_val > SAT_MAX)
      bn_out = SAT_MAX[DATA_WIDTH-1:0];
`ifdef BN_RELU6_EN
    if (!s_val[SW-1] && (s_val > SIX_MAX))
      bn_out = SIX_MAX[DATA_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_reg     <= 1'b0;
      v2_reg     <= 1'b0;
      last1_reg  <= 1'b0;
      last2_reg  <= 1'b0;
      x1_reg     <= '0;
      prod2_reg  <= '0;
      bias2_reg  <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      pxl_out    <= '0;
    end else begin
      v1_reg    <= accept;
      last1_reg <= accept && last_pxl;
      if (accept)
        x1_reg <= pxl_in;
      v2_reg    <= v1_reg;
      last2_reg <= v1_reg && last1_reg;
      if (v1_reg) begin
        prod2_reg <= PW'(x1_reg) * PW'(scale_rd_reg);
        bias2_reg <= bias_rd_reg;
      end
      valid_out  <= v2_reg;
      frame_done <= v2_reg && last2_reg;
      if (v2_reg)
        pxl_out <= bn_out;
    end
  end

endmodule
